// File: rtl/sample_streamer.sv
// Sample playback engine: streams a small register memory out over a
// valid/ready port, either looping forever or for a fixed number of periods.
module sample_streamer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int SHIFT  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic              stop,
    input  logic              mode,
    input  logic [ADDR_W:0]   len,
    input  logic [7:0]        reps,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [15:0]       sample_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              r_mode;
    logic [ADDR_W-1:0] r_last_idx;
    logic [7:0]        r_reps;
    logic [ADDR_W-1:0] r_idx;
    logic [7:0]        r_per;
    logic              r_valid;
    logic              r_last;
    logic [DATA_W-1:0] r_data;
    logic [15:0]       r_cnt;

    logic [ADDR_W-1:0] w_last_idx;
    logic [7:0]        w_reps_eff;
    logic              w_start;
    logic              w_xfer;
    logic              w_at_end;
    logic [7:0]        w_per_nxt;
    logic              w_finish;
    logic [ADDR_W-1:0] w_idx_inc;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [DATA_W-1:0] w_rd_data;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // len of 0 or beyond DEPTH both collapse to a full-memory period
    assign w_last_idx = (len == '0 || len > DEPTH_L) ? '1
                      : (len[ADDR_W-1:0] - ADDR_W'(1));
    assign w_reps_eff = (reps == 8'd0) ? 8'd1 : reps;

    assign w_start   = (r_state == S_IDLE) && start && !stop;
    assign w_xfer    = r_valid && out_ready;
    assign w_at_end  = (r_idx == r_last_idx);
    assign w_per_nxt = r_per + 8'd1;
    assign w_finish  = w_xfer && w_at_end && r_mode
                    && (w_per_nxt == r_reps);
    assign w_idx_inc = r_idx + ADDR_W'(1);
    assign w_rd_addr = (r_state == S_RUN && !w_at_end) ? w_idx_inc : '0;
    assign w_rd_data = r_mem[w_rd_addr] << SHIFT;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (w_finish) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mode     <= 1'b0;
            r_last_idx <= '0;
            r_reps     <= 8'd0;
            r_idx      <= '0;
            r_per      <= 8'd0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_data     <= '0;
            r_cnt      <= 16'd0;
        end else if (w_start) begin
            r_mode     <= mode;
            r_last_idx <= w_last_idx;
            r_reps     <= w_reps_eff;
            r_idx      <= '0;
            r_per      <= 8'd0;
            r_valid    <= 1'b1;
            r_last     <= (w_last_idx == '0);
            r_data     <= w_rd_data;
            r_cnt      <= 16'd0;
        end else if (r_state == S_RUN) begin
            if (w_xfer && r_cnt != 16'hFFFF) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (stop) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end else if (w_xfer) begin
                if (w_at_end) begin
                    r_idx <= '0;
                    r_per <= w_per_nxt;
                    if (w_finish) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                    end else begin
                        r_data <= w_rd_data;
                        r_last <= (r_last_idx == '0);
                    end
                end else begin
                    r_idx  <= w_idx_inc;
                    r_data <= w_rd_data;
                    r_last <= (w_idx_inc == r_last_idx);
                end
            end
        end
    end

    assign out_valid  = r_valid;
    assign out_data   = r_data;
    assign out_last   = r_last;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign sample_cnt = r_cnt;

endmodule

// File: tb/tb_sample_streamer.sv
// Scoreboard bench for sample_streamer: stimulus pushes expected samples,
// a negedge monitor pops and compares each transfer and checks stall holds.
module tb_sample_streamer;

    localparam int DW = 16;
    localparam int AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          start;
    logic          stop;
    logic          mode;
    logic [AW:0]   len;
    logic [7:0]    reps;
    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;
    logic [15:0]   sample_cnt;

    logic          s_wr_en;
    logic [AW-1:0] s_wr_addr;
    logic [DW-1:0] s_wr_data;
    logic          s_start;
    logic          s_stop;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          s_busy;
    logic          s_done;
    logic [15:0]   s_cnt;

    sample_streamer #(.DATA_W(DW), .ADDR_W(AW), .SHIFT(0)) u_dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .stop(stop),
        .mode(mode), .len(len), .reps(reps),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done), .sample_cnt(sample_cnt)
    );

    sample_streamer #(.DATA_W(DW), .ADDR_W(AW), .SHIFT(6)) u_shift (
        .clk(clk), .reset(reset),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .start(s_start), .stop(s_stop),
        .mode(1'b1), .len(6'd1), .reps(8'd1),
        .out_valid(s_valid), .out_ready(1'b0),
        .out_data(s_data), .out_last(s_last),
        .busy(s_busy), .done(s_done), .sample_cnt(s_cnt)
    );

    int n_pass = 0;
    int n_total = 0;
    logic [DW:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d, input logic l);
        exp_q.push_back({l, d});
    endtask

    always @(negedge clk) begin
        if (reset && out_valid) begin
            if (exp_q.size() == 0) begin
                if (out_ready) begin
                    n_total++;
                    $display("FAIL unexpected_xfer: got data %0h, none queued",
                             out_data);
                end
            end else if (out_ready) begin
                check("xfer", {15'd0, out_last, out_data},
                      {15'd0, exp_q.pop_front()});
            end else begin
                check("stall_hold", {15'd0, out_last, out_data},
                      {15'd0, exp_q[0]});
            end
        end
    end

    task automatic run_oneshot(input logic [AW:0] l, input logic [7:0] r,
                               input int le, input int n);
        int c;
        for (int i = 0; i < n; i++) begin
            push(DW'((i % le) + 1), (i % le) == le - 1);
        end
        mode  = 1'b1;
        len   = l;
        reps  = r;
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 0;
        while (!done && c < 1000) begin
            tick();
            c++;
        end
        check("oneshot_done_latency", c, n);
        check("oneshot_valid_off", out_valid, 0);
        check("oneshot_cnt", sample_cnt, n);
        tick();
        check("oneshot_done_pulse_end", done, 0);
        check("oneshot_busy_end", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c;
        reset = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; stop = 1'b0;
        mode = 1'b0; len = '0; reps = '0;
        out_ready = 1'b1;
        s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0;
        s_start = 1'b0; s_stop = 1'b0;
        repeat (3) tick();
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cnt", sample_cnt, 0);
        reset = 1'b1;

        for (int i = 0; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = DW'(i + 1);
            tick();
        end
        wr_en = 1'b0;

        // start and stop together in IDLE stays idle
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        tick();
        check("startstop_busy", busy, 0);
        check("startstop_valid", out_valid, 0);

        // loop mode, full memory, 128 back-to-back transfers
        for (int i = 0; i < 128; i++) push(DW'((i % 32) + 1), (i % 32) == 31);
        mode = 1'b0; len = '0; reps = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("loop_first_data", out_data, 16'd1);
        check("loop_busy", busy, 1);
        repeat (128) tick();
        out_ready = 1'b0;
        check("loop_cnt_128", sample_cnt, 128);
        check("loop_wrap_data", out_data, 16'd1);
        check("loop_wrap_last", out_last, 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("loop_stop_valid", out_valid, 0);
        check("loop_stop_busy", busy, 0);
        check("loop_stop_done", done, 0);
        check("loop_stop_cnt", sample_cnt, 128);
        out_ready = 1'b1;

        run_oneshot(6'd4, 8'd3, 4, 12);
        run_oneshot(6'd40, 8'd1, 32, 32);
        run_oneshot(6'd1, 8'd0, 1, 1);

        // ready pattern 1,0,0,1 with an ignored start mid-run
        for (int i = 0; i < 4; i++) push(DW'(i + 1), i == 3);
        mode = 1'b1; len = 6'd4; reps = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 0;
        while (!done && c < 100) begin
            out_ready = (c % 4 == 0) || (c % 4 == 3);
            start = (c == 5);
            tick();
            c++;
        end
        start = 1'b0;
        out_ready = 1'b1;
        check("stall_done_seen", done, 1);
        check("stall_cnt", sample_cnt, 4);
        tick();

        // write to the presented address only affects the next load
        push(16'd1, 1'b0); push(16'd2, 1'b1);
        push(16'h00AA, 1'b0); push(16'd2, 1'b1);
        mode = 1'b1; len = 6'd2; reps = 8'd2;
        out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b1; wr_addr = '0; wr_data = 16'h00AA;
        tick();
        wr_en = 1'b0;
        check("wr_held_data", out_data, 16'd1);
        out_ready = 1'b1;
        c = 0;
        while (!done && c < 100) begin
            tick();
            c++;
        end
        check("wr_done_seen", done, 1);
        check("wr_cnt", sample_cnt, 4);
        wr_en = 1'b1; wr_addr = '0; wr_data = 16'd1;
        tick();
        wr_en = 1'b0;

        // stop during the 5th valid cycle; that transfer is counted
        for (int i = 0; i < 5; i++) push(DW'(i + 1), 1'b0);
        mode = 1'b0; len = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_valid", out_valid, 0);
        check("stop_busy", busy, 0);
        check("stop_done", done, 0);
        check("stop_cnt", sample_cnt, 5);
        tick();
        check("stop_no_done_later", done, 0);

        // reset mid-run
        for (int i = 0; i < 3; i++) push(DW'(i + 1), 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        out_ready = 1'b0;
        reset = 1'b0;
        tick();
        check("mrst_valid", out_valid, 0);
        check("mrst_last", out_last, 0);
        check("mrst_data", out_data, 0);
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_cnt", sample_cnt, 0);
        reset = 1'b1;
        out_ready = 1'b1;
        tick();
        check("mrst_stays_idle", out_valid, 0);

        // SHIFT=6 instance truncates 0x0401<<6 to 0x0040
        s_wr_en = 1'b1; s_wr_addr = '0; s_wr_data = 16'h0401;
        tick();
        s_wr_en = 1'b0;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        check("shift_valid", s_valid, 1);
        check("shift_data", s_data, 16'h0040);
        check("shift_last", s_last, 1);
        s_stop = 1'b1;
        tick();
        s_stop = 1'b0;
        check("shift_stop_busy", s_busy, 0);

        tick();
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sample_streamer.md
SAMPLE_STREAMER -- requirements
Module: sample_streamer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, memory address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter SHIFT, default 0, left-shift applied to each output sample, truncated to DATA_W.
REQ-004 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have ports: reset  in  1  synchronous, active-low reset.
REQ-006 SHALL have ports: wr_en  in  1  memory write strobe; wr_addr  in  ADDR_W  write address; wr_data  in  DATA_W  write data.
REQ-007 SHALL have ports: start  in  1  begin playback; stop  in  1  abort playback.
REQ-008 SHALL have ports: mode  in  1  0 = loop forever, 1 = one-shot; len  in  ADDR_W+1  samples per period; reps  in  8  periods in one-shot.
REQ-009 SHALL have ports: out_valid  out  1; out_ready  in  1; out_data  out  DATA_W; out_last  out  1  last sample of period.
REQ-010 SHALL have ports: busy  out  1  state != IDLE; done  out  1  one-cycle completion pulse; sample_cnt  out  16  samples transferred since start.

Function
REQ-011 SHALL hold a DEPTH x DATA_W register array, written at the edge where wr_en=1, in any state; contents are not cleared by reset.
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 SHALL latch mode, len, reps at the edge where start=1 in IDLE; len=0 or len>DEPTH is treated as DEPTH; reps=0 is treated as 1.
REQ-014 SHALL, on start in IDLE: enter RUN, set read index to 0, load out_data = mem[0]<<SHIFT, assert out_valid from the next cycle (latency 1), and clear sample_cnt and period counter.
REQ-015 SHALL hold out_data and out_last stable while out_valid=1 and out_ready=0.
REQ-016 SHALL, on transfer (out_valid & out_ready) with index < len-1, advance index by 1 and load the next sample at the same edge (one sample per cycle at full throughput).
REQ-017 SHALL assert out_last exactly while the presented sample has index len-1.
REQ-018 SHALL, on transfer at index len-1, wrap index to 0 and increment the period counter; in mode 1, when the completed period count equals latched reps, go to DONE with out_valid=0 next cycle.
REQ-019 SHALL, in mode 0, wrap indefinitely with no gap between periods.
REQ-020 SHALL increment sample_cnt on every transfer, saturating at 16'hFFFF.
REQ-021 SHALL, in DONE, assert done=1 for exactly one cycle, then return to IDLE.
REQ-022 SHALL, on stop=1 in RUN, go to IDLE at the next edge with out_valid=0 and no done pulse; stop takes priority over a simultaneous transfer (that sample is counted only if handshake completes at the same edge, i.e. sample_cnt includes it).
REQ-023 SHALL ignore start while in RUN or DONE; in IDLE, start and stop together leave the block in IDLE.
REQ-024 SHALL apply a memory write to the currently presented address only to the next load, not to the held out_data.

Reset
REQ-025 SHALL, when reset=0 at a rising edge, go to IDLE with out_valid=0, out_last=0, out_data=0, busy=0, done=0, sample_cnt=0, index=0, period counter=0, regardless of state, including mid-playback.

Verification
REQ-026 Load mem[i]=i+1 for i=0..31, mode=0, len=0, out_ready=1, start -> out_data 1,2..32,1,2.. each cycle, out_last on 32, sample_cnt=128 after 128 cycles of valid.
REQ-027 mode=1, len=4, reps=3, out_ready=1 -> 12 samples 1,2,3,4 x3, out_last on each 4, done pulse one cycle after last transfer, busy low after.
REQ-028 SHIFT=6 build, mem[0]=16'h0401 -> out_data=16'h0040 (truncation).
REQ-029 out_ready toggled 1,0,0,1 during playback -> out_data stable through stalls, no sample skipped or repeated.
REQ-030 stop asserted at 5th valid cycle, and separately reset=0 mid-run -> out_valid low next cycle, no done; reset case shows all outputs at reset values.
